// File: rtl/rr_arbiter4_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter.
// Includes the one-hot to index helper used for owner tracking.
package rr_arbiter4_pkg;

   localparam int NREQ  = 4;
   localparam int PTR_W = 2;
   localparam int CNT_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = idx | PTR_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters and the arbiter.
// slave = arbiter side (consumes req/done, drives grant); master = requester side.
interface rr_arbiter4_if;
   import rr_arbiter4_pkg::*;

   logic [NREQ-1:0] req;
   logic            done;
   logic [NREQ-1:0] gnt;
   logic            gnt_valid;
   logic            timeout;

   modport slave  (input  req, done, output gnt, gnt_valid, timeout);
   modport master (output req, done, input  gnt, gnt_valid, timeout);

endinterface

// File: rtl/rr_arbiter4_pick.sv
// Combinational round-robin pick: one-hot of first set req bit starting at ptr.
// Zero latency; pick is zero when req is zero.
module rr_pick4
   import rr_arbiter4_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  pick
);

   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic [NREQ-1:0]   pick_rot;
   logic [2*NREQ-1:0] pick_dbl;

   // Rotate so ptr lands at bit 0, isolate lowest set bit, rotate back.
   assign req_dbl  = {req, req} >> ptr;
   assign req_rot  = req_dbl[NREQ-1:0];
   assign pick_rot = req_rot & (~req_rot + NREQ'(1));
   assign pick_dbl = {pick_rot, pick_rot} << ptr;
   assign pick     = pick_dbl[2*NREQ-1:NREQ];

endmodule

// File: rtl/rr_arbiter4.sv
// 4-way round-robin arbiter with hold limit; grant registered 1 cycle after req in IDLE.
// Grants drop for at least one cycle between owners; owner release by done, req drop or HOLD_MAX.
module rr_arbiter4
   import rr_arbiter4_pkg::*;
#(
   parameter int HOLD_MAX = 15
)
(
   input  logic          clk,
   input  logic          rst,
   rr_arbiter4_if.slave  arb
);

   localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_MAX);

   state_e            state_q, state_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              gnt_valid_q, gnt_valid_d;
   logic              timeout_q, timeout_d;
   logic [NREQ-1:0]   pick;

   rr_pick4 u_pick (
      .req  (arb.req),
      .ptr  (ptr_q),
      .pick (pick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;

      case (state_q)
         IDLE: begin
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
            if (|arb.req) begin
               state_d     = GRANT;
               owner_d     = onehot_to_idx(pick);
               gnt_d       = pick;
               gnt_valid_d = 1'b1;
               cnt_d       = CNT_W'(1);
            end
         end
         GRANT: begin
            // done wins over expiry, so timeout only flags a genuinely forced release.
            if (arb.done || !arb.req[owner_q] || (cnt_q >= HOLD_CNT)) begin
               state_d     = IDLE;
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               ptr_d       = owner_q + PTR_W'(1);
               cnt_d       = '0;
               timeout_d   = !arb.done && arb.req[owner_q];
            end else begin
               cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   assign arb.gnt       = gnt_q;
   assign arb.gnt_valid = gnt_valid_q;
   assign arb.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed and random checks of rr_arbiter4 with HOLD_MAX = 3.
module tb_rr_arbiter4;
   import rr_arbiter4_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   rr_arbiter4_if ifc ();

   rr_arbiter4 #(.HOLD_MAX(3)) dut (
      .clk (clk),
      .rst (rst),
      .arb (ifc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic exp_out(input string tag, input logic [3:0] g, input logic t);
      chk($sformatf("%s.gnt", tag), 32'(ifc.gnt), 32'(g));
      chk($sformatf("%s.vld", tag), 32'(ifc.gnt_valid), 32'(g != 4'b0000));
      chk($sformatf("%s.tmo", tag), 32'(ifc.timeout), 32'(t));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      ifc.req  = 4'b0000;
      ifc.done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_out("rst", 4'b0000, 1'b0);
      rst = 1'b0;
   endtask

   function automatic logic [3:0] ref_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      for (int k = 0; k < 4; k++) begin
         idx = p + 2'(k);
         if (r[idx]) return 4'(1) << idx;
      end
      return 4'b0000;
   endfunction

   function automatic int ref_idx(input logic [3:0] oh);
      for (int k = 0; k < 4; k++) if (oh[k]) return k;
      return 0;
   endfunction

   logic [3:0] req_drv, prev_gnt, g, e;
   logic       done_drv;
   logic [1:0] ptr_m;
   int         waits [4];
   int         worst;

   initial begin
      do_reset();

      // Idle with no request; done must be ignored.
      ifc.done = 1'b1;
      step(); exp_out("idle_done", 4'b0000, 1'b0);
      ifc.done = 1'b0;

      // Full request, each owner releases via done after two grant cycles.
      ifc.req = 4'b1111;
      for (int o = 0; o < 4; o++) begin
         step(); exp_out($sformatf("rr%0d.g", o), 4'(1) << o, 1'b0);
         step(); exp_out($sformatf("rr%0d.h", o), 4'(1) << o, 1'b0);
         ifc.done = 1'b1;
         step(); exp_out($sformatf("rr%0d.r", o), 4'b0000, 1'b0);
         ifc.done = 1'b0;
      end
      step(); exp_out("rr.wrap", 4'b0001, 1'b0);

      // Hold limit expiry, then done coinciding with expiry.
      do_reset();
      ifc.req = 4'b0100;
      step(); exp_out("hold.c1", 4'b0100, 1'b0);
      step(); exp_out("hold.c2", 4'b0100, 1'b0);
      step(); exp_out("hold.c3", 4'b0100, 1'b0);
      step(); exp_out("hold.tmo", 4'b0000, 1'b1);
      step(); exp_out("hold.regrant", 4'b0100, 1'b0);
      step(); exp_out("hold.c2b", 4'b0100, 1'b0);
      step(); exp_out("hold.c3b", 4'b0100, 1'b0);
      ifc.done = 1'b1;
      step(); exp_out("hold.prec", 4'b0000, 1'b0);
      ifc.done = 1'b0;
      ifc.req  = 4'b0000;

      // Owner drops request; non-owner changes ignored; pointer wrap 3 -> 0.
      do_reset();
      ifc.req = 4'b0010;
      step(); exp_out("drop.g", 4'b0010, 1'b0);
      ifc.req = 4'b0000;
      step(); exp_out("drop.r", 4'b0000, 1'b0);
      ifc.req = 4'b1111;
      step(); exp_out("drop.ptr2", 4'b0100, 1'b0);
      ifc.req = 4'b1100;
      step(); exp_out("ign.nonown", 4'b0100, 1'b0);
      ifc.done = 1'b1;
      step(); exp_out("ign.rel", 4'b0000, 1'b0);
      ifc.done = 1'b0;
      ifc.req  = 4'b1001;
      step(); exp_out("wrap.g3", 4'b1000, 1'b0);
      ifc.done = 1'b1;
      step(); exp_out("wrap.rel", 4'b0000, 1'b0);
      ifc.done = 1'b0;
      step(); exp_out("wrap.g0", 4'b0001, 1'b0);

      // Asynchronous reset mid-grant.
      do_reset();
      ifc.req = 4'b1000;
      step(); exp_out("arst.g", 4'b1000, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      chk("arst.gnt", 32'(ifc.gnt), 32'(4'b0000));
      chk("arst.vld", 32'(ifc.gnt_valid), 32'(1'b0));
      @(negedge clk);
      rst = 1'b0;
      step(); exp_out("arst.after", 4'b1000, 1'b0);

      // Random traffic with a small round-robin reference.
      do_reset();
      ptr_m    = 2'd0;
      prev_gnt = 4'b0000;
      req_drv  = 4'b0000;
      done_drv = 1'b0;
      for (int k = 0; k < 4; k++) waits[k] = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         step();
         g = ifc.gnt;
         chk("rnd.onehot", 32'($countones(g) <= 1), 32'd1);
         chk("rnd.vld", 32'(ifc.gnt_valid), 32'(g != 4'b0000));
         if (prev_gnt == 4'b0000) begin
            e = ref_pick(req_drv, ptr_m);
            chk("rnd.pick", 32'(g), 32'(e));
            chk("rnd.tmo_idle", 32'(ifc.timeout), 32'd0);
            if (e != 4'b0000) begin
               chk("rnd.enc", 32'(onehot_to_idx(g)), 32'(ref_idx(e)));
               worst = 0;
               for (int k = 0; k < 4; k++) begin
                  if (req_drv[k] && !e[k]) waits[k]++;
                  else waits[k] = 0;
                  if (waits[k] > worst) worst = waits[k];
               end
               chk("rnd.starve", 32'(worst <= 3), 32'd1);
            end
         end else begin
            if (done_drv || !(|(req_drv & prev_gnt)))
               chk("rnd.release", 32'(g), 32'd0);
            else if (g != 4'b0000)
               chk("rnd.hold", 32'(g), 32'(prev_gnt));
            chk("rnd.tmo", 32'(ifc.timeout),
                32'(g == 4'b0000 && !done_drv && (|(req_drv & prev_gnt))));
            if (g == 4'b0000) ptr_m = 2'(ref_idx(prev_gnt) + 1);
         end
         prev_gnt = g;
         if ($urandom_range(0, 3) == 0) req_drv = 4'($urandom);
         done_drv = ($urandom_range(0, 7) == 0);
         ifc.req  = req_drv;
         ifc.done = done_drv;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter HOLD_MAX, default 15, maximum number of consecutive cycles one grant may be held before forced release; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  request lines; req[i] high = requester i wants the shared resource.
REQ-005 done  input  1  current owner has finished; sampled only while a grant is active.
REQ-006 gnt  output  4  registered grant vector; always all-zero or exactly one-hot; feeds the downstream one-hot-to-binary encoder.
REQ-007 gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-008 timeout  output  1  one-cycle pulse on a forced release caused by HOLD_MAX expiry.

Function
REQ-009 FSM states: IDLE and GRANT; all outputs are registered, with no combinational path from input to output.
REQ-010 Rotating pointer ptr[1:0] = highest-priority index; the search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-011 IDLE with req != 0: next edge enter GRANT, gnt = one-hot of first set bit in search order, gnt_valid = 1, hold counter = 1; latency from req assertion to gnt is 1 cycle.
REQ-012 IDLE with req == 0: stay IDLE, gnt = 0, ptr unchanged.
REQ-013 GRANT hold: stay while req[owner] = 1, done = 0, and hold counter < HOLD_MAX; the counter increments by 1 per cycle, saturating 8-bit.
REQ-014 GRANT release on done = 1 or req[owner] = 0: next edge enter IDLE, gnt = 0, gnt_valid = 0, ptr = owner+1 mod 4 (wrap 3 -> 0).
REQ-015 GRANT forced release when the hold counter reaches HOLD_MAX with done = 0 and req[owner] = 1: same as REQ-014, plus timeout = 1 for that one cycle.
REQ-016 When several release causes coincide, done takes precedence; timeout asserts only if done = 0 and req[owner] = 1.
REQ-017 Every grant is followed by at least one gnt = 0 cycle (IDLE), so downstream never sees a grant-to-grant change without a gap.
REQ-018 Changes on req to non-owner bits during GRANT are ignored; arbitration uses req as sampled in IDLE.
REQ-019 done during IDLE is ignored.
REQ-020 gnt never has more than one bit set, in any state or after any input sequence.

Reset
REQ-021 rst high asynchronously forces state = IDLE, gnt = 4'b0000, gnt_valid = 0, timeout = 0, ptr = 0, and hold counter = 0.
REQ-022 rst asserted mid-grant drops gnt immediately, without waiting for a clock edge.
REQ-023 After rst deasserts, the first grant follows REQ-011 with ptr = 0.

Structure
REQ-024 A shared package holds the state enum (IDLE, GRANT), NREQ = 4, PTR_W = 2, and CNT_W = 8.
REQ-025 One combinational sub-module, rr_pick4, computes the one-hot pick from (req, ptr); rr_arbiter4 holds the FSM, pointer, counter and output registers.

Verification
REQ-026 Reset, then req = 4'b1111: gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001, with each owner releasing via done after 2 cycles.
REQ-027 req = 4'b0100 only, held with done = 0, HOLD_MAX = 3: gnt = 0100 for exactly 3 cycles, then timeout pulse, then gnt = 0000, then gnt = 0100 again.
REQ-028 Owner 1 drops req[1] mid-grant while done = 0: gnt = 0000 on the next edge, ptr = 2, and timeout stays 0.
REQ-029 Assert rst asynchronously between edges while gnt = 1000: gnt = 0000 and gnt_valid = 0 before the next edge; after release, req = 4'b1000 gives gnt = 1000 one cycle later.
REQ-030 Random req/done for 10k cycles: gnt is always zero or one-hot, gnt_valid == (gnt != 0), no owner starves beyond 4 grants, and the encoder output matches the owner index.
